// File: rtl/multi_stage_synchronizer.sv
// multi_stage_synchronizer
// Per-channel STAGES-deep synchronizer for WIDTH independent single-bit inputs,
// with registered rise/fall pulses on the synchronized level.
// Optional stability filter: define MULTI_STAGE_SYNC_FILTER_EN to require the
// synchronized level to differ from out for FILTER_CYCLES enabled cycles before
// out follows it. Without the macro no counters exist and FILTER_CYCLES is unused.
module multi_stage_synchronizer #(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Reject configurations the structure cannot represent.
    generate
        if (WIDTH < 1 || STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
            $error("multi_stage_synchronizer: illegal WIDTH/STAGES/FILTER_CYCLES");
        end
    endgenerate

    // sync_p[0] is the only flop that samples the asynchronous input.
    logic [WIDTH-1:0] sync_p [STAGES];

    // Synchronizer chain: shifts one place per enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_p[k] <= RESET_VALUE;
            end
        end else if (enable) begin
            sync_p[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

`ifdef MULTI_STAGE_SYNC_FILTER_EN

    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] sync_last;
    logic [CNT_W-1:0] cnt [WIDTH];

    assign sync_last = sync_p[STAGES-1];

    // Stability filter: out follows the synchronized level only after it has
    // disagreed with out for FILTER_CYCLES consecutive enabled edges; any
    // agreement restarts the count, so the counter never reaches its wrap point.
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= RESET_VALUE;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (enable) begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_last[i] == out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    out[i]  <= sync_last[i];
                    rise[i] <= sync_last[i];
                    fall[i] <= ~sync_last[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end

`else

    // The last chain stage is itself the registered output.
    assign out = sync_p[STAGES-1];

    // Edge pulses are computed from the value about to enter the last stage,
    // so they line up with the cycle in which out first shows the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else if (enable) begin
            rise <= sync_p[STAGES-2] & ~sync_p[STAGES-1];
            fall <= ~sync_p[STAGES-2] & sync_p[STAGES-1];
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end

`endif

endmodule
